// File: rtl/sha_host_pkg.sv
// sha_host_pkg: shared states, constants and helpers for the SHA host controller
package sha_host_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_MODE      = 3'd1;
  localparam state_t S_LEN_HI    = 3'd2;
  localparam state_t S_LEN_LO    = 3'd3;
  localparam state_t S_PAYLOAD   = 3'd4;
  localparam state_t S_DRAIN     = 3'd5;
  localparam state_t S_WAIT_HASH = 3'd6;
  localparam state_t S_TX        = 3'd7;
  localparam int MODE_HEX_BIT = 0;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
  endfunction
endpackage

// File: rtl/sha_byte_fifo.sv
// sha_byte_fifo: synchronous FIFO of {last, byte} payload entries with flush
module sha_byte_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign empty = cnt == '0;
  assign full = cnt[AW];
  assign rd = pop && !empty;
  // a full FIFO still takes a byte when one leaves in the same cycle
  assign wr = push && (!full || rd);
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
    end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
endmodule

// File: rtl/sha_host_ctrl.sv
// sha_host_ctrl: parses UART frames, feeds payload to the SHA padder, and returns the digest raw or as hex
module sha_host_ctrl
  import sha_host_pkg::*;
#(
  parameter int DIGEST_W = 256,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter logic [7:0] SOF_BYTE = 8'hA5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_dv,
  input  logic [7:0]          rx_byte,
  output logic                msg_valid,
  output logic [7:0]          msg_byte,
  output logic                msg_last,
  input  logic                msg_ready,
  output logic                msg_empty,
  output logic                msg_abort,
  input  logic                hash_done,
  input  logic [DIGEST_W-1:0] hash_digest,
  output logic                tx_dv,
  output logic [7:0]          tx_byte,
  input  logic                tx_active,
  input  logic                tx_done,
  output logic                busy,
  output logic                err_timeout,
  output logic                err_overrun
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int CW = $clog2(DIGEST_W/4+2);
  localparam int NRAW = DIGEST_W/8;
  localparam int NHEX = DIGEST_W/4;
  state_t state;
  logic hex, out, full, empty, push, pop, flush, overrun, timeout, counting, issue, tx_last;
  logic [15:0] rem;
  logic [TW-1:0] tcnt;
  logic [CW-1:0] kc;
  logic [DIGEST_W-1:0] dig, src;
  logic [8:0] fifo_q;
  logic [7:0] nxt_byte;
  sha_byte_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .pop(pop),
    .din({rem == 16'd1, rx_byte}), .dout(fifo_q), .full(full), .empty(empty)
  );
  assign pop = !empty && msg_ready;
  assign msg_valid = !empty;
  assign msg_byte = empty ? 8'h00 : fifo_q[7:0];
  assign msg_last = !empty && fifo_q[8];
  assign busy = state != S_IDLE;
  assign overrun = state == S_PAYLOAD && rx_dv && full && !pop;
  assign push = state == S_PAYLOAD && rx_dv && !overrun;
  assign counting = state inside {S_MODE, S_LEN_HI, S_LEN_LO, S_PAYLOAD};
  assign timeout = counting && !rx_dv && tcnt == TW'(TIMEOUT_CYC-1);
  assign flush = overrun || timeout;
  // the first byte goes straight from hash_digest so tx_dv can follow hash_done by one cycle
  assign src = state == S_WAIT_HASH ? hash_digest : dig;
  assign tx_last = kc == (hex ? CW'(NHEX+2) : CW'(NRAW));
  assign issue = !tx_active && ((state == S_WAIT_HASH && hash_done) ||
                                (state == S_TX && !tx_last && (!out || tx_done)));
  assign nxt_byte = !hex ? src[DIGEST_W-1 -: 8] :
                    kc < CW'(NHEX) ? nib2ascii(src[DIGEST_W-1 -: 4]) :
                    kc == CW'(NHEX) ? CR : LF;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      hex <= 1'b0;
      out <= 1'b0;
      rem <= '0;
      tcnt <= '0;
      kc <= '0;
      dig <= '0;
      msg_empty <= 1'b0;
      msg_abort <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      tx_dv <= 1'b0;
      tx_byte <= '0;
    end else begin
      msg_empty <= state == S_LEN_LO && rx_dv && {rem[15:8], rx_byte} == 16'd0;
      msg_abort <= flush;
      err_overrun <= overrun;
      err_timeout <= timeout;
      tx_dv <= issue;
      tcnt <= counting && !rx_dv ? tcnt + 1'b1 : '0;
      if (issue) begin
        tx_byte <= nxt_byte;
        kc <= kc + 1'b1;
        out <= 1'b1;
      end else if (tx_done) out <= 1'b0;
      if (issue || (state == S_WAIT_HASH && hash_done)) dig <= !issue ? src : hex ? src << 4 : src << 8;
      case (state)
        S_IDLE: begin
          kc <= '0;
          if (rx_dv && rx_byte == SOF_BYTE) state <= S_MODE;
        end
        S_MODE: if (rx_dv) begin
          hex <= rx_byte[MODE_HEX_BIT];
          state <= S_LEN_HI;
        end
        S_LEN_HI: if (rx_dv) begin
          rem[15:8] <= rx_byte;
          state <= S_LEN_LO;
        end
        S_LEN_LO: if (rx_dv) begin
          rem[7:0] <= rx_byte;
          state <= {rem[15:8], rx_byte} == 16'd0 ? S_WAIT_HASH : S_PAYLOAD;
        end
        S_PAYLOAD: if (push) begin
          rem <= rem - 1'b1;
          if (rem == 16'd1) state <= S_DRAIN;
        end
        S_DRAIN: if (empty) state <= S_WAIT_HASH;
        S_WAIT_HASH: if (hash_done) state <= S_TX;
        S_TX: if (tx_last && tx_done) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (flush) state <= S_IDLE;
    end
endmodule

// File: tb/tb_sha_host_ctrl.sv
// tb_sha_host_ctrl: directed frame tests with a UART TX model and hand-computed digests
module tb_sha_host_ctrl;
  localparam int TO = 20;
  localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  logic clk = 0, rst_n = 0, rx_dv = 0, msg_ready = 0, hash_done = 0;
  logic [7:0] rx_byte = 0;
  logic [255:0] hash_digest = 0;
  logic tx_active, tx_done;
  logic msg_valid, msg_last, msg_empty, msg_abort, tx_dv, busy, err_timeout, err_overrun;
  logic [7:0] msg_byte, tx_byte;
  int checks = 0, failures = 0;
  int cyc = 0, hd_cyc = 0, tm = 0, ovl = 0;
  int n_empty = 0, n_abort = 0, n_tov = 0, n_ovr = 0;
  logic [7:0] txq[$], mq[$];
  logic lq[$];
  int dv_q[$], done_q[$];
  sha_host_ctrl #(.DIGEST_W(256), .FIFO_DEPTH(4), .TIMEOUT_CYC(TO), .SOF_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .msg_valid(msg_valid), .msg_byte(msg_byte), .msg_last(msg_last), .msg_ready(msg_ready),
    .msg_empty(msg_empty), .msg_abort(msg_abort), .hash_done(hash_done), .hash_digest(hash_digest),
    .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_active(tx_active), .tx_done(tx_done),
    .busy(busy), .err_timeout(err_timeout), .err_overrun(err_overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_active <= 1'b0;
      tx_done <= 1'b0;
      tm <= 0;
    end else begin
      tx_done <= 1'b0;
      if (tx_dv) begin
        tx_active <= 1'b1;
        tm <= 3;
      end else if (tx_active) begin
        tm <= tm - 1;
        if (tm == 1) begin
          tx_active <= 1'b0;
          tx_done <= 1'b1;
        end
      end
    end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_dv) begin
      txq.push_back(tx_byte);
      dv_q.push_back(cyc);
      if (tx_active) ovl <= ovl + 1;
    end
    if (tx_done) done_q.push_back(cyc);
    if (hash_done) hd_cyc <= cyc;
    if (msg_valid && msg_ready) begin
      mq.push_back(msg_byte);
      lq.push_back(msg_last);
    end
    if (msg_empty) n_empty <= n_empty + 1;
    if (msg_abort) n_abort <= n_abort + 1;
    if (err_timeout) n_tov <= n_tov + 1;
    if (err_overrun) n_ovr <= n_ovr + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] hexc(input logic [3:0] n);
    return n > 4'd9 ? 8'h61 + 8'(n) - 8'd10 : 8'h30 + 8'(n);
  endfunction
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_dv = 1;
    rx_byte = b;
    @(posedge clk);
    #1 rx_dv = 0;
  endtask
  task automatic hash(input logic [255:0] d);
    @(negedge clk);
    hash_done = 1;
    hash_digest = d;
    @(negedge clk);
    hash_done = 0;
  endtask
  task automatic wait_tx(input int target);
    for (int i = 0; i < 3000 && done_q.size() < target; i++) begin
      @(posedge clk);
      #1;
    end
    check("tx_count", txq.size(), target);
    check("busy_end", busy, 0);
  endtask
  task automatic check_raw(input string tag, input int n0, input logic [255:0] d);
    int bad = 0;
    for (int i = 0; i < 32; i++)
      if (n0 + i >= txq.size() || txq[n0+i] !== d[255-8*i -: 8]) bad++;
    check(tag, bad, 0);
  endtask
  task automatic run_abc(input logic [7:0] mode, output int n0);
    int m0;
    n0 = txq.size();
    m0 = mq.size();
    msg_ready = 1;
    send(8'hA5); send(mode); send(8'h00); send(8'h03);
    send(8'h61); send(8'h62); send(8'h63);
    for (int i = 0; i < 50 && mq.size() < m0 + 3; i++) @(posedge clk);
    check("beats", mq.size() - m0, 3);
    if (mq.size() >= m0 + 3) begin
      check("beat0", {mq[m0], 7'd0, lq[m0]}, 16'h6100);
      check("beat1", {mq[m0+1], 7'd0, lq[m0+1]}, 16'h6200);
      check("beat2", {mq[m0+2], 7'd0, lq[m0+2]}, 16'h6301);
    end
    repeat (4) @(posedge clk);
    hash(D_ABC);
    wait_tx(n0 + (mode[0] ? 66 : 32));
    if (dv_q.size() > n0) check("first_tx_lat", dv_q[n0] - hd_cyc, 1);
  endtask
  initial begin
    int n0, m0, e0, a0, t0, bad;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {msg_valid, msg_byte, msg_last, msg_empty, msg_abort, tx_dv, tx_byte, busy, err_timeout, err_overrun}, 0);
    @(negedge clk) rst_n = 1;
    repeat (2) @(posedge clk);
    // 1: raw digest
    run_abc(8'h00, n0);
    check_raw("raw_abc", n0, D_ABC);
    if (txq.size() >= n0 + 32) check("raw_ends", {txq[n0], txq[n0+1], txq[n0+30], txq[n0+31]}, 32'hba7815ad);
    // 2: hex digest with CR LF
    run_abc(8'h01, n0);
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (n0 + i >= txq.size() || txq[n0+i] !== hexc(D_ABC[255-4*i -: 4])) bad++;
    check("hex_chars", bad, 0);
    if (txq.size() >= n0 + 66) begin
      check("hex_head", {txq[n0], txq[n0+1]}, 16'h6261);
      check("hex_crlf", {txq[n0+64], txq[n0+65]}, 16'h0d0a);
    end
    bad = 0;
    for (int i = n0; i + 1 < n0 + 66 && i + 1 < dv_q.size() && i < done_q.size(); i++)
      if (dv_q[i+1] != done_q[i] + 1) bad++;
    check("tx_gap", bad, 0);
    // 3: empty message
    n0 = txq.size();
    m0 = mq.size();
    e0 = n_empty;
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    repeat (4) @(posedge clk);
    check("empty_strobe", n_empty - e0, 1);
    check("empty_nobeat", mq.size() - m0, 0);
    hash(D_EMPTY);
    wait_tx(n0 + 32);
    check_raw("raw_empty", n0, D_EMPTY);
    // 4: overrun with a stalled padder
    msg_ready = 0;
    a0 = n_abort;
    send(8'hA5); send(8'h00); send(8'h00); send(8'h08);
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i));
    check("ovr_none_yet", err_overrun, 0);
    check("ovr_valid", msg_valid, 1);
    send(8'h14);
    check("ovr_strobe", {err_overrun, msg_abort}, 2'b11);
    check("ovr_idle", {busy, msg_valid}, 2'b00);
    @(posedge clk);
    #1;
    check("ovr_1cycle", err_overrun, 0);
    check("ovr_aborts", n_abort - a0, 1);
    // 5: timeout and terminal-cycle rescue
    t0 = n_tov;
    send(8'hA5); send(8'h00);
    bad = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (err_timeout) begin
        bad = i;
        break;
      end
    end
    check("tov_latency", bad, TO);
    check("tov_abort", {msg_abort, busy}, 2'b10);
    send(8'hA5); send(8'h00);
    repeat (TO - 1) @(posedge clk);
    send(8'h00);
    check("tov_rescued", {err_timeout, busy}, 2'b01);
    check("tov_count", n_tov - t0, 1);
    repeat (TO + 5) @(posedge clk);
    #1;
    check("tov_later_idle", busy, 0);
    // 6: junk bytes, then reset in the middle of TX
    send(8'h7F);
    check("junk_7f", busy, 0);
    send(8'h33);
    check("junk_33", busy, 0);
    n0 = txq.size();
    msg_ready = 1;
    send(8'hA5); send(8'h00); send(8'h00); send(8'h03);
    send(8'h61); send(8'h62); send(8'h63);
    repeat (6) @(posedge clk);
    hash(D_ABC);
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (tx_dv && txq.size() >= n0 + 4) break;
    end
    check("pre_rst_txdv", tx_dv, 1);
    rst_n = 0;
    #1;
    check("rst_txdv_busy", {tx_dv, busy}, 2'b00);
    @(negedge clk) rst_n = 1;
    repeat (2) @(posedge clk);
    run_abc(8'h00, n0);
    check_raw("raw_after_rst", n0, D_ABC);
    check("tx_overlap", ovl, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
